// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// master = producer/consumer side, slave = multiplier side.
interface seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   is_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     p;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 iterative shift-add multiplier, one partial product per cycle.
// Signed operands are converted to magnitudes on capture; the sign is
// reapplied on the last iteration so no extra cycle is spent.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  seq_multiplier_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [CW-1:0]        cnt_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic                 neg_reg;

  logic                 transfer;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0]   prod_next;

  assign transfer = (state_reg == IDLE) && bus.in_valid;

  // Operand magnitudes; |-2^(WIDTH-1)| still fits in WIDTH unsigned bits.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  // One shift-add step: add multiplicand to upper half if LSB set, shift right.
  assign sum     = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                 + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign shifted = {sum, prod_reg[WIDTH-1:1]};
  assign prod_next = (cnt_reg == LAST && neg_reg)
                   ? (~shifted + (2*WIDTH)'(1)) : shifted;

  // State register; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; clear overrides any transfer in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)     state_next = BUSY;
      BUSY:    if (cnt_reg == LAST)  state_next = DONE;
      DONE:    if (bus.out_ready)    state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Outputs decoded from state; product is only visible in DONE.
  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.out_valid = (state_reg == DONE);
    bus.p         = (state_reg == DONE) ? prod_reg : '0;
  end

  // Datapath: capture operands on transfer, iterate while BUSY.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg   <= '0;
      mcand_reg <= '0;
      prod_reg  <= '0;
      neg_reg   <= 1'b0;
    end else if (transfer) begin
      cnt_reg   <= '0;
      mcand_reg <= a_mag;
      prod_reg  <= {{WIDTH{1'b0}}, b_mag};
      neg_reg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end else if (state_reg == BUSY) begin
      cnt_reg   <= cnt_reg + 1'b1;
      prod_reg  <= prod_next;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8: vector table plus
// hand-written backpressure, reset-abort and clear sequences.
module tb_seq_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp_p;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation; release controls whether output is consumed.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp_p,
                        input bit release_out);
    int  waited;
    bit  early;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready_timeout", 0, 1);
    bus.a = a; bus.b = b; bus.is_signed = s; bus.in_valid = 1'b1;
    tick();  // transfer edge
    // scramble inputs and wiggle ignored handshakes during BUSY
    bus.a = W'($urandom); bus.b = W'($urandom); bus.is_signed = ~s;
    bus.out_ready = 1'b1;
    early = 0;
    for (int i = 1; i <= W; i++) begin
      tick();
      if (i < W && (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)) early = 1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check($sformatf("latency a=%0h b=%0h s=%0b", a, b, s),
          {62'd0, early, bus.out_valid}, 64'd1);
    check($sformatf("p a=%0h b=%0h s=%0b", a, b, s), 64'(bus.p), 64'(exp_p));
    $display("op a=0x%0h b=0x%0h s=%0b -> p=0x%0h (exp 0x%0h)", a, b, s, bus.p, exp_p);
    if (release_out) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("release", {bus.in_ready, bus.out_valid, 16'(bus.p)}, {1'b1, 1'b0, 16'h0});
    end
  endtask

  initial begin
    bit bad;
    logic [2*W-1:0] held;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
    vecs[3]  = '{8'h00, 8'hA5, 1'b0, 16'h0000};
    vecs[4]  = '{8'h01, 8'hA5, 1'b1, 16'hFFA5};
    vecs[5]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
    vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[7]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[9]  = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
    vecs[10] = '{8'h0C, 8'hF6, 1'b1, 16'hFF88};

    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    tick(); tick();
    check("reset_state", {bus.in_ready, bus.out_valid, 16'(bus.p)}, {1'b1, 1'b0, 16'h0});
    rst = 1'b0;  // first transfer happens on the very next edge

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_p, 1'b1);

    // Backpressure: product held five cycles, then released.
    run_op(8'h0C, 8'h0B, 1'b0, 16'h0084, 1'b0);
    held = bus.p;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.p !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1;
    end
    check("backpressure_hold", {63'd0, bad}, 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("backpressure_release", {bus.in_ready, bus.out_valid}, 2'b10);
    $display("backpressure sequence done");

    // Reset in BUSY cycle 3: operation must vanish.
    bus.a = 8'h11; bus.b = 8'h22; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy_state", {bus.in_ready, bus.out_valid, 16'(bus.p)}, {1'b1, 1'b0, 16'h0});
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) bad = 1;
      tick();
    end
    check("rst_no_out_valid", {63'd0, bad}, 64'd0);
    $display("reset abort sequence done");
    run_op(8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);

    // Clear coincident with a transfer: transfer dropped.
    bus.a = 8'h07; bus.b = 8'h09; bus.in_valid = 1'b1; clear = 1'b1;
    tick();
    bus.in_valid = 1'b0; clear = 1'b0;
    check("clear_drop_state", {bus.in_ready, bus.out_valid}, 2'b10);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) bad = 1;
      tick();
    end
    check("clear_drop_no_out", {63'd0, bad}, 64'd0);
    $display("clear on transfer sequence done");

    // Clear in DONE with out_ready: product dropped, p forced to 0.
    run_op(8'h05, 8'h06, 1'b0, 16'h001E, 1'b0);
    clear = 1'b1; bus.out_ready = 1'b1;
    tick();
    clear = 1'b0; bus.out_ready = 1'b0;
    check("clear_in_done", {bus.in_ready, bus.out_valid, 16'(bus.p)}, {1'b1, 1'b0, 16'h0});
    $display("clear in done sequence done");

    // Clear mid-BUSY, then a normal operation still works.
    bus.a = 8'h33; bus.b = 8'h44; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) bad = 1;
      tick();
    end
    check("clear_mid_busy", {63'd0, bad}, 64'd0);
    $display("clear in busy sequence done");
    run_op(8'hF0, 8'h02, 1'b1, 16'hFFE0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 clear  input  1  synchronous abort; returns block to IDLE.
REQ-005 in_valid  input  1  operands and mode presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 out_valid  output  1  product available.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 p  output  2*WIDTH  full-width product.

Function
REQ-013 The block SHALL implement a radix-2 iterative shift-add multiplier with states IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 An operand transfer occurs on a rising edge with in_valid=1 and in_ready=1; a, b and is_signed SHALL be latched on that edge, and the state SHALL move IDLE->BUSY.
REQ-016 Input changes outside a transfer edge SHALL have no effect on the result.
REQ-017 BUSY SHALL last exactly WIDTH cycles, one partial-product iteration per cycle, counted by an internal counter of ceil(log2(WIDTH+1)) bits.
REQ-018 out_valid SHALL first be 1 in the cycle following the WIDTH-th edge after the transfer edge, a latency of WIDTH cycles.
REQ-019 Unsigned mode: p SHALL equal a*b, zero-extended, exact over 2*WIDTH bits.
REQ-020 Signed mode: p SHALL equal the two's-complement product of a and b over 2*WIDTH bits, including a = b = -2^(WIDTH-1).
REQ-021 Signed handling may use magnitude-plus-final-negate or Baugh-Wooley correction, provided it adds no cycles beyond REQ-018.
REQ-022 In DONE, p and out_valid SHALL hold stable until an edge with out_ready=1.
REQ-023 On that edge the state SHALL move DONE->IDLE; in_ready SHALL be 1 in the next cycle.
REQ-024 There is no same-cycle output-to-input bypass: at most one operation is in flight.
REQ-025 Outside DONE, p SHALL read 0.
REQ-026 clear=1 on any edge SHALL force IDLE, discard any operation in progress or pending, and drive out_valid=0 and p=0 in the next cycle.
REQ-027 clear has priority over a simultaneous operand transfer, which is dropped.
REQ-028 clear has priority over a simultaneous output transfer; the product is dropped.
REQ-029 out_ready while not in DONE, and in_valid while not in IDLE, SHALL be ignored.

Reset
REQ-030 rst=1 on a rising edge SHALL force IDLE, zero the iteration counter and all datapath registers, and give in_ready=1, out_valid=0, p=0 in the next cycle.
REQ-031 rst SHALL take priority over clear, operand transfer and output transfer.
REQ-032 rst asserted mid-BUSY or in DONE SHALL discard the operation with no later out_valid for it.
REQ-033 The first operand transfer SHALL be possible on the first edge with rst=0.

Verification (WIDTH=8)
REQ-034 Unsigned maximum: a=0xFF, b=0xFF, is_signed=0 -> out_valid 8 cycles after transfer, p=0xFE01.
REQ-035 Signed corner and mixed sign:
- a=0x80, b=0x80, is_signed=1 -> p=0x4000.
- a=0xFF, b=0x7F, is_signed=1 -> p=0xFF81.
REQ-036 Zero and identity: a=0x00, b=0xA5 -> p=0x0000; then a=0x01, b=0xA5, is_signed=1 -> p=0xFFA5.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> p and out_valid stable and in_ready=0 throughout; release -> in_ready=1 the next cycle.
REQ-038 Abort:
- rst at BUSY cycle 3 -> no out_valid; the next transfer a=3, b=5 gives p=0x000F.
- clear asserted coincident with a transfer -> that transfer is dropped.
